// File: rtl/ika3012_serial_dac.sv
// YM3012-style serial DAC front end: deserialises SO slots on SH1/SH2 falling edges and
// decodes the 3-bit exponent / 10-bit mantissa word to 16-bit linear. Optional: IKA3012_STEREO_SYNC_EN.
module ika3012_serial_dac #(
    parameter bit MUTE_ON_ERR = 1'b0
) (
    input  logic        i_EMUCLK,
    input  logic        i_IC_n,
    input  logic        i_phi1_PCEN_n,
    input  logic        i_SO,
    input  logic        i_SH1,
    input  logic        i_SH2,
    output logic [15:0] o_CH1,
    output logic [15:0] o_CH2,
    output logic        o_CH1_VALID,
    output logic        o_CH2_VALID,
    output logic        o_FRAME_ERR
);

    logic        tick;
    logic        ld1;
    logic        ld2;
    logic        frame_ok;
    logic [15:0] dec;

    logic [15:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sh1_prev_q, sh1_prev_d;
    logic        sh2_prev_q, sh2_prev_d;
    logic [15:0] ch1_q, ch1_d;
    logic [15:0] ch2_q, ch2_d;
    logic        v1_q, v1_d;
    logic        v2_q, v2_d;
    logic        err_q, err_d;
`ifdef IKA3012_STEREO_SYNC_EN
    logic [15:0] hold_q, hold_d;
`endif

    // E=0 is mute; otherwise the sign-extended mantissa is shifted up by E-1 (never overflows 16 bits).
    function automatic logic [15:0] decode(input logic [2:0] e, input logic [9:0] m);
        logic [15:0] ext;
        logic [15:0] res;
        ext = {{6{m[9]}}, m};
        res = 16'h0000;
        if (e != 3'd0) begin
            res = ext << (e - 3'd1);
        end
        return res;
    endfunction

    always_comb begin
        tick     = ~i_phi1_PCEN_n;
        ld1      = tick & sh1_prev_q & ~i_SH1;
        ld2      = tick & sh2_prev_q & ~i_SH2;
        frame_ok = (cnt_q == 5'd16);
        dec      = decode(sr_q[15:13], sr_q[12:3]);
    end

    // Shift register, bit counter and strobe history; loads see sr/cnt from before this tick.
    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        sh1_prev_d = sh1_prev_q;
        sh2_prev_d = sh2_prev_q;
        err_d      = err_q;
        if (tick) begin
            sr_d       = {i_SO, sr_q[15:1]};
            sh1_prev_d = i_SH1;
            sh2_prev_d = i_SH2;
            if (ld1 || ld2) begin
                cnt_d = 5'd1;
            end else if (cnt_q != 5'd31) begin
                cnt_d = cnt_q + 5'd1;
            end
            if (((ld1 || ld2) && !frame_ok) || (ld1 && ld2)) begin
                err_d = 1'b1;
            end
        end
    end

`ifdef IKA3012_STEREO_SYNC_EN
    // CH1 is parked in hold_q and released together with CH2 so both channels change in one cycle.
    always_comb begin
        hold_d = hold_q;
        ch1_d  = ch1_q;
        ch2_d  = ch2_q;
        v1_d   = 1'b0;
        v2_d   = 1'b0;
        if (ld1) begin
            if (frame_ok) begin
                hold_d = dec;
            end else if (MUTE_ON_ERR) begin
                hold_d = 16'h0000;
            end
        end
        if (ld2) begin
            ch1_d = hold_d;
            if (frame_ok) begin
                ch2_d = dec;
            end else if (MUTE_ON_ERR) begin
                ch2_d = 16'h0000;
            end
            v1_d = 1'b1;
            v2_d = 1'b1;
        end
    end
`else
    always_comb begin
        ch1_d = ch1_q;
        ch2_d = ch2_q;
        v1_d  = 1'b0;
        v2_d  = 1'b0;
        if (ld1) begin
            v1_d = 1'b1;
            if (frame_ok) begin
                ch1_d = dec;
            end else if (MUTE_ON_ERR) begin
                ch1_d = 16'h0000;
            end
        end
        if (ld2) begin
            v2_d = 1'b1;
            if (frame_ok) begin
                ch2_d = dec;
            end else if (MUTE_ON_ERR) begin
                ch2_d = 16'h0000;
            end
        end
    end
`endif

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            sr_q       <= 16'h0000;
            cnt_q      <= 5'd0;
            sh1_prev_q <= 1'b0;
            sh2_prev_q <= 1'b0;
            ch1_q      <= 16'h0000;
            ch2_q      <= 16'h0000;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            sh1_prev_q <= sh1_prev_d;
            sh2_prev_q <= sh2_prev_d;
            ch1_q      <= ch1_d;
            ch2_q      <= ch2_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            err_q      <= err_d;
        end
    end

`ifdef IKA3012_STEREO_SYNC_EN
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            hold_q <= 16'h0000;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign o_CH1       = ch1_q;
    assign o_CH2       = ch2_q;
    assign o_CH1_VALID = v1_q;
    assign o_CH2_VALID = v2_q;
    assign o_FRAME_ERR = err_q;

endmodule
